// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 16-bit accumulator CPU control path.
//   - instruction opcodes (ir[15:12])
//   - ALU operation codes driven on alu_opcode
//   - sequencer state encoding
//   - datapath mux select encodings (pc_sel, mar_sel, mbr_sel, acc_sel)
//   - SKIPCOND condition field encodings (ir[11:10])
// ----------------------------------------------------------------------------
package cpu_pkg;

    // Instruction opcodes
    localparam logic [3:0] OP_LOAD     = 4'h1;
    localparam logic [3:0] OP_STORE    = 4'h2;
    localparam logic [3:0] OP_ADD      = 4'h3;
    localparam logic [3:0] OP_SUBT     = 4'h4;
    localparam logic [3:0] OP_HALT     = 4'h7;
    localparam logic [3:0] OP_SKIPCOND = 4'h8;
    localparam logic [3:0] OP_JUMP     = 4'h9;
    localparam logic [3:0] OP_CLEAR    = 4'hA;

    // ALU operations: operand1 = ACC, operand2 = MBR
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;

    // Datapath mux selects
    localparam logic       PC_SEL_INC      = 1'b0;
    localparam logic       PC_SEL_OPERAND  = 1'b1;
    localparam logic       MAR_SEL_PC      = 1'b0;
    localparam logic       MAR_SEL_OPERAND = 1'b1;
    localparam logic       MBR_SEL_MEM     = 1'b0;
    localparam logic       MBR_SEL_ACC     = 1'b1;
    localparam logic [1:0] ACC_SEL_ALU     = 2'd0;
    localparam logic [1:0] ACC_SEL_MBR     = 2'd1;
    localparam logic [1:0] ACC_SEL_ZERO    = 2'd2;

    // SKIPCOND condition field
    localparam logic [1:0] SKIP_NEG   = 2'b00;
    localparam logic [1:0] SKIP_ZERO  = 2'b01;
    localparam logic [1:0] SKIP_POS   = 2'b10;
    localparam logic [1:0] SKIP_NEVER = 2'b11;

    // Sequencer states
    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_F_ADDR   = 4'd1,
        ST_F_READ   = 4'd2,
        ST_F_IR     = 4'd3,
        ST_DECODE   = 4'd4,
        ST_EX_READ  = 4'd5,
        ST_EX_MBR   = 4'd6,
        ST_EX_ACC   = 4'd7,
        ST_EX_WRITE = 4'd8,
        ST_HALT     = 4'd9
    } seq_state_t;

    // Instructions that fetch an operand from memory into MBR and then
    // update ACC share the same EX_READ/EX_MBR/EX_ACC path.
    function automatic logic op_reads_operand(input logic [3:0] op);
        return (op == OP_LOAD) || (op == OP_ADD) || (op == OP_SUBT);
    endfunction

endpackage

// File: rtl/cpu_control_sequencer_skip_cond_eval.sv
// ----------------------------------------------------------------------------
// skip_cond_eval
// Combinational evaluation of the SKIPCOND test against the accumulator.
// Ports:
//   cond      in   2  condition field ir[11:10]
//   acc       in  16  accumulator, two's-complement
//   take_skip out  1  high when the selected condition holds
// ----------------------------------------------------------------------------
module skip_cond_eval
    import cpu_pkg::*;
(
    input  logic [1:0]  cond,
    input  logic [15:0] acc,
    output logic        take_skip
);

    logic acc_neg;
    logic acc_zero;

    assign acc_neg  = acc[15];
    assign acc_zero = (acc == 16'h0000);

    // Positive means strictly greater than zero: not negative and not zero.
    always_comb begin
        take_skip = 1'b0;
        case (cond)
            SKIP_NEG:   take_skip = acc_neg;
            SKIP_ZERO:  take_skip = acc_zero;
            SKIP_POS:   take_skip = !acc_neg && !acc_zero;
            SKIP_NEVER: take_skip = 1'b0;
            default:    take_skip = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_control_sequencer.sv
// ----------------------------------------------------------------------------
// cpu_control_sequencer
// Moore-style fetch/decode/execute sequencer for the accumulator CPU.
// Ports:
//   clock          in        system clock, all state changes on posedge
//   reset_n        in        asynchronous active-low reset
//   start          in        one-cycle pulse, leaves IDLE or HALT
//   ir             in   16   current IR contents, opcode [15:12]
//   acc            in   16   current ACC contents
//   pc_we/pc_sel   out       PC load, 0 = PC+1, 1 = IR operand
//   mar_we/mar_sel out       MAR load, 0 = PC, 1 = IR operand
//   mbr_we/mbr_sel out       MBR load, 0 = memory data_out, 1 = ACC
//   ir_we          out       IR load from memory data_out
//   acc_we/acc_sel out       ACC load, 0 = ALU, 1 = MBR, 2 = zero
//   alu_opcode     out   4   ALU operation (ACC op MBR)
//   mem_we         out       memory write of MBR at MAR
//   halted         out       high in HALT
//   illegal        out       sticky undefined-opcode flag
//   instr_retired  out CNT_W retired-instruction count (wraps)
// ----------------------------------------------------------------------------
module cpu_control_sequencer
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 16
)
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [15:0]      ir,
    input  logic [15:0]      acc,
    output logic             pc_we,
    output logic             pc_sel,
    output logic             mar_we,
    output logic             mar_sel,
    output logic             mbr_we,
    output logic             mbr_sel,
    output logic             ir_we,
    output logic             acc_we,
    output logic [1:0]       acc_sel,
    output logic [3:0]       alu_opcode,
    output logic             mem_we,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_retired
);

    seq_state_t state;
    seq_state_t next_state;

    logic [3:0] opcode;
    logic [1:0] skip_cond;
    logic       take_skip;
    logic       unused_operand_bits;

    // Opcode captured in DECODE; EX_ACC must pick its ALU/mux setting from
    // it because outputs outside DECODE depend only on state.
    logic [3:0] exec_op;

    logic retire;
    logic set_illegal;
    logic clear_illegal;

    assign opcode              = ir[15:12];
    assign skip_cond           = ir[ADDR_W-1 -: 2];
    assign unused_operand_bits = ^ir[ADDR_W-3:0];

    skip_cond_eval u_skip_cond_eval (
        .cond      (skip_cond),
        .acc       (acc),
        .take_skip (take_skip)
    );

    // State register and the opcode latched for the execute phase.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            exec_op <= 4'h0;
        end else begin
            state <= next_state;
            if (state == ST_DECODE) begin
                exec_op <= opcode;
            end
        end
    end

    // Sticky illegal flag, cleared only by restarting from HALT.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            illegal <= 1'b0;
        end else if (set_illegal) begin
            illegal <= 1'b1;
        end else if (clear_illegal) begin
            illegal <= 1'b0;
        end
    end

    // Retired-instruction counter; wraps silently.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            instr_retired <= '0;
        end else if (retire) begin
            instr_retired <= instr_retired + CNT_W'(1);
        end
    end

    // Next-state and output decode. Everything defaults to inactive so each
    // state only lists what it asserts.
    always_comb begin
        next_state    = state;
        pc_we         = 1'b0;
        pc_sel        = PC_SEL_INC;
        mar_we        = 1'b0;
        mar_sel       = MAR_SEL_PC;
        mbr_we        = 1'b0;
        mbr_sel       = MBR_SEL_MEM;
        ir_we         = 1'b0;
        acc_we        = 1'b0;
        acc_sel       = ACC_SEL_ALU;
        alu_opcode    = ALU_ADD;
        mem_we        = 1'b0;
        halted        = 1'b0;
        retire        = 1'b0;
        set_illegal   = 1'b0;
        clear_illegal = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = ST_F_ADDR;
                end
            end

            ST_F_ADDR: begin
                mar_we     = 1'b1;
                mar_sel    = MAR_SEL_PC;
                next_state = ST_F_READ;
            end

            // Memory registers its read data on this edge.
            ST_F_READ: begin
                next_state = ST_F_IR;
            end

            ST_F_IR: begin
                ir_we      = 1'b1;
                pc_we      = 1'b1;
                pc_sel     = PC_SEL_INC;
                next_state = ST_DECODE;
            end

            ST_DECODE: begin
                if (op_reads_operand(opcode)) begin
                    mar_we     = 1'b1;
                    mar_sel    = MAR_SEL_OPERAND;
                    next_state = ST_EX_READ;
                end else begin
                    case (opcode)
                        OP_STORE: begin
                            mar_we     = 1'b1;
                            mar_sel    = MAR_SEL_OPERAND;
                            mbr_we     = 1'b1;
                            mbr_sel    = MBR_SEL_ACC;
                            next_state = ST_EX_WRITE;
                        end
                        // PC already points past the SKIPCOND, so a second
                        // increment skips exactly one instruction.
                        OP_SKIPCOND: begin
                            pc_we      = take_skip;
                            pc_sel     = PC_SEL_INC;
                            retire     = 1'b1;
                            next_state = ST_F_ADDR;
                        end
                        OP_JUMP: begin
                            pc_we      = 1'b1;
                            pc_sel     = PC_SEL_OPERAND;
                            retire     = 1'b1;
                            next_state = ST_F_ADDR;
                        end
                        OP_CLEAR: begin
                            acc_we     = 1'b1;
                            acc_sel    = ACC_SEL_ZERO;
                            retire     = 1'b1;
                            next_state = ST_F_ADDR;
                        end
                        OP_HALT: begin
                            retire     = 1'b1;
                            next_state = ST_HALT;
                        end
                        // Undefined opcode: stop without counting it.
                        default: begin
                            set_illegal = 1'b1;
                            next_state  = ST_HALT;
                        end
                    endcase
                end
            end

            ST_EX_READ: begin
                next_state = ST_EX_MBR;
            end

            ST_EX_MBR: begin
                mbr_we     = 1'b1;
                mbr_sel    = MBR_SEL_MEM;
                next_state = ST_EX_ACC;
            end

            ST_EX_ACC: begin
                acc_we = 1'b1;
                retire = 1'b1;
                case (exec_op)
                    OP_LOAD: begin
                        acc_sel = ACC_SEL_MBR;
                    end
                    OP_SUBT: begin
                        acc_sel    = ACC_SEL_ALU;
                        alu_opcode = ALU_SUB;
                    end
                    default: begin
                        acc_sel    = ACC_SEL_ALU;
                        alu_opcode = ALU_ADD;
                    end
                endcase
                next_state = ST_F_ADDR;
            end

            ST_EX_WRITE: begin
                mem_we     = 1'b1;
                retire     = 1'b1;
                next_state = ST_F_ADDR;
            end

            // Restart resumes at the current PC.
            ST_HALT: begin
                halted = 1'b1;
                if (start) begin
                    clear_illegal = 1'b1;
                    next_state    = ST_F_ADDR;
                end
            end

            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// ----------------------------------------------------------------------------
// tb_cpu_control_sequencer
// Drives the sequencer through a small behavioural datapath (PC, MAR, MBR,
// IR, ACC, ALU, synchronous memory) and checks its outputs and the effects
// of whole programs through an expected-value queue.
// ----------------------------------------------------------------------------
module tb_cpu_control_sequencer;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        pc_we, pc_sel, mar_we, mar_sel, mbr_we, mbr_sel;
    logic        ir_we, acc_we, mem_we, halted, illegal;
    logic [1:0]  acc_sel;
    logic [3:0]  alu_opcode;
    logic [15:0] instr_retired;

    // Behavioural datapath
    logic [11:0] pc;
    logic [11:0] mar;
    logic [15:0] mbr;
    logic [15:0] ir_q;
    logic [15:0] acc_q;
    logic [15:0] mem_q;
    logic [15:0] alu_result;
    logic [15:0] mem [0:4095];

    // Memory loader
    logic        load_en;
    logic [11:0] load_addr;
    logic [15:0] load_data;
    logic        clear_mem;

    logic [15:0] out_vec;

    typedef struct {
        string       tag;
        logic [31:0] value;
    } exp_t;

    exp_t exp_q[$];
    int   n_compared;
    int   n_mismatched;

    cpu_control_sequencer #(.ADDR_W(12), .CNT_W(16)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .start         (start),
        .ir            (ir_q),
        .acc           (acc_q),
        .pc_we         (pc_we),
        .pc_sel        (pc_sel),
        .mar_we        (mar_we),
        .mar_sel       (mar_sel),
        .mbr_we        (mbr_we),
        .mbr_sel       (mbr_sel),
        .ir_we         (ir_we),
        .acc_we        (acc_we),
        .acc_sel       (acc_sel),
        .alu_opcode    (alu_opcode),
        .mem_we        (mem_we),
        .halted        (halted),
        .illegal       (illegal),
        .instr_retired (instr_retired)
    );

    assign out_vec = {pc_we, pc_sel, mar_we, mar_sel, mbr_we, mbr_sel, ir_we,
                      acc_we, acc_sel, alu_opcode, mem_we, halted};

    assign alu_result = (alu_opcode == 4'b0001) ? (acc_q - mbr) : (acc_q + mbr);

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Datapath registers follow the sequencer's enables and selects.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc    <= 12'h000;
            mar   <= 12'h000;
            mbr   <= 16'h0000;
            ir_q  <= 16'h0000;
            acc_q <= 16'h0000;
            mem_q <= 16'h0000;
        end else begin
            if (pc_we)  pc   <= pc_sel ? ir_q[11:0] : pc + 12'd1;
            if (mar_we) mar  <= mar_sel ? ir_q[11:0] : pc;
            if (mbr_we) mbr  <= mbr_sel ? acc_q : mem_q;
            if (ir_we)  ir_q <= mem_q;
            if (acc_we) begin
                case (acc_sel)
                    2'd0:    acc_q <= alu_result;
                    2'd1:    acc_q <= mbr;
                    2'd2:    acc_q <= 16'h0000;
                    default: acc_q <= acc_q;
                endcase
            end
            mem_q <= mem[mar];
        end
    end

    // Memory array: bench loader or the sequencer's write strobe.
    always @(posedge clock) begin
        if (clear_mem) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 16'h0000;
        end else if (load_en) begin
            mem[load_addr] <= load_data;
        end else if (mem_we) begin
            mem[mar] <= mbr;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no completion, expected summary before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic expect_val(input string tag, input logic [31:0] value);
        exp_t e;
        e.tag   = tag;
        e.value = value;
        exp_q.push_back(e);
    endtask

    task automatic observe(input logic [31:0] actual);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL scoreboard: got 0x%0h, expected nothing queued", actual);
        end else begin
            e = exp_q.pop_front();
            checkOutput(e.tag, actual, e.value);
        end
    endtask

    task automatic report_timeout(input string tag);
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL %s: got timeout, expected event within budget", tag);
    endtask

    // Hold reset and wipe memory; reset stays asserted on return.
    task automatic do_reset();
        reset_n   = 1'b0;
        start     = 1'b0;
        clear_mem = 1'b1;
        @(negedge clock);
        clear_mem = 1'b0;
        @(negedge clock);
    endtask

    task automatic load_word(input logic [11:0] addr, input logic [15:0] data);
        load_en   = 1'b1;
        load_addr = addr;
        load_data = data;
        @(negedge clock);
        load_en   = 1'b0;
    endtask

    // Release reset and let the sequencer sit in IDLE for two cycles.
    task automatic applyStimulus();
        reset_n = 1'b1;
        @(negedge clock);
        @(negedge clock);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_halt(input int budget, output int cycles);
        cycles = 0;
        while (!halted && cycles < budget) begin
            @(negedge clock);
            cycles++;
        end
        if (!halted) report_timeout("wait_halt");
    endtask

    // Returns at the negedge inside the DECODE following the next F_IR.
    task automatic wait_decode(input int budget);
        int cycles;
        cycles = 0;
        while (!ir_we && cycles < budget) begin
            @(negedge clock);
            cycles++;
        end
        if (!ir_we) report_timeout("wait_decode");
        @(negedge clock);
    endtask

    function automatic void skip_case(input int i, output logic [15:0] a,
                                      output logic [1:0] c, output logic e);
        case (i)
            0:       begin a = 16'hFFFF; c = 2'b00; e = 1'b1; end
            1:       begin a = 16'h0001; c = 2'b00; e = 1'b0; end
            2:       begin a = 16'h0000; c = 2'b00; e = 1'b0; end
            3:       begin a = 16'h0000; c = 2'b01; e = 1'b1; end
            4:       begin a = 16'h0005; c = 2'b01; e = 1'b0; end
            5:       begin a = 16'h0001; c = 2'b10; e = 1'b1; end
            6:       begin a = 16'h7FFF; c = 2'b10; e = 1'b1; end
            7:       begin a = 16'h8000; c = 2'b10; e = 1'b0; end
            8:       begin a = 16'h0000; c = 2'b11; e = 1'b0; end
            default: begin a = 16'hFFFF; c = 2'b11; e = 1'b0; end
        endcase
    endfunction

    initial begin
        int          cyc;
        logic [15:0] s_acc;
        logic [1:0]  s_cond;
        logic        s_exp;

        n_compared   = 0;
        n_mismatched = 0;
        reset_n      = 1'b0;
        start        = 1'b0;
        load_en      = 1'b0;
        load_addr    = 12'h000;
        load_data    = 16'h0000;
        clear_mem    = 1'b0;

        // Reset state, then LOAD/ADD/STORE/HALT program
        do_reset();
        load_word(12'h000, 16'h1010);
        load_word(12'h001, 16'h3011);
        load_word(12'h002, 16'h2012);
        load_word(12'h003, 16'h7000);
        load_word(12'h010, 16'd5);
        load_word(12'h011, 16'd7);
        expect_val("rst_outputs", 32'h0);
        expect_val("rst_retired", 32'h0);
        expect_val("rst_illegal", 32'h0);
        observe(out_vec);
        observe(instr_retired);
        observe(illegal);

        expect_val("idle_outputs", 32'h0);
        expect_val("start_mar_we", 32'h1);
        expect_val("start_mar_sel", 32'h0);
        expect_val("start_retired", 32'h0);
        expect_val("add_halt_cycles", 32'd23);
        expect_val("add_retired", 32'd4);
        expect_val("add_mem12", 32'd12);
        expect_val("add_acc", 32'd12);
        applyStimulus();
        observe(out_vec);
        pulse_start();
        observe(mar_we);
        observe(mar_sel);
        observe(instr_retired);
        wait_halt(100, cyc);
        observe(cyc);
        observe(instr_retired);
        observe(mem[12'h012]);
        observe(acc_q);

        // LOAD/SUBT/STORE/HALT with a negative result
        do_reset();
        load_word(12'h000, 16'h1010);
        load_word(12'h001, 16'h4011);
        load_word(12'h002, 16'h2012);
        load_word(12'h003, 16'h7000);
        load_word(12'h010, 16'd3);
        load_word(12'h011, 16'd10);
        expect_val("sub_halt_cycles", 32'd23);
        expect_val("sub_mem12", 32'h0000FFF9);
        expect_val("sub_retired", 32'd4);
        applyStimulus();
        pulse_start();
        wait_halt(100, cyc);
        observe(cyc);
        observe(mem[12'h012]);
        observe(instr_retired);

        // SKIPCOND table
        for (int i = 0; i < 10; i++) begin
            skip_case(i, s_acc, s_cond, s_exp);
            do_reset();
            load_word(12'h000, 16'h1020);
            load_word(12'h001, {4'h8, s_cond, 10'h000});
            load_word(12'h002, 16'h7000);
            load_word(12'h003, 16'h7000);
            load_word(12'h020, s_acc);
            expect_val($sformatf("skip%0d_pc_we", i), {31'h0, s_exp});
            expect_val($sformatf("skip%0d_final_pc", i), s_exp ? 32'd4 : 32'd3);
            applyStimulus();
            pulse_start();
            wait_decode(20);
            wait_decode(20);
            observe(pc_we);
            wait_halt(50, cyc);
            observe(pc);
        end

        // JUMP, then LOAD and CLEAR at the jump target
        do_reset();
        load_word(12'h000, 16'h9005);
        load_word(12'h005, 16'h1020);
        load_word(12'h006, 16'hA000);
        load_word(12'h007, 16'h7000);
        load_word(12'h020, 16'h1234);
        expect_val("jump_pc_we", 32'h1);
        expect_val("jump_pc_sel", 32'h1);
        expect_val("jump_fetch_pc", 32'h005);
        expect_val("jump_fetch_mar", 32'h005);
        expect_val("load_exacc_we_sel", 32'b101);
        expect_val("clear_acc_before", 32'h1234);
        expect_val("clear_acc_we", 32'h1);
        expect_val("clear_acc_sel", 32'h2);
        expect_val("jump_final_acc", 32'h0);
        expect_val("jump_retired", 32'd4);
        applyStimulus();
        pulse_start();
        wait_decode(20);
        observe(pc_we);
        observe(pc_sel);
        @(negedge clock);
        observe(pc);
        @(negedge clock);
        observe(mar);
        wait_decode(20);
        repeat (3) @(negedge clock);
        observe({acc_we, acc_sel});
        wait_decode(20);
        observe(acc_q);
        observe(acc_we);
        observe(acc_sel);
        wait_halt(50, cyc);
        observe(acc_q);
        observe(instr_retired);

        // Undefined opcode, then restart from HALT
        do_reset();
        load_word(12'h000, 16'hF000);
        load_word(12'h001, 16'h7000);
        expect_val("ill_cycles", 32'd4);
        expect_val("ill_flag", 32'h1);
        expect_val("ill_halted", 32'h1);
        expect_val("ill_retired", 32'h0);
        expect_val("resume_illegal", 32'h0);
        expect_val("resume_pc", 32'h001);
        expect_val("resume_mar_we", 32'h1);
        expect_val("resume_retired", 32'd1);
        expect_val("resume_halted", 32'h1);
        expect_val("resume_illegal_end", 32'h0);
        applyStimulus();
        pulse_start();
        wait_halt(50, cyc);
        observe(cyc);
        observe(illegal);
        observe(halted);
        observe(instr_retired);
        pulse_start();
        observe(illegal);
        observe(pc);
        observe(mar_we);
        wait_halt(50, cyc);
        observe(instr_retired);
        observe(halted);
        observe(illegal);

        // Reset asserted during EX_WRITE of STORE
        do_reset();
        load_word(12'h000, 16'h1010);
        load_word(12'h001, 16'h2012);
        load_word(12'h002, 16'h7000);
        load_word(12'h010, 16'd9);
        expect_val("st_mem_we_before", 32'h1);
        expect_val("st_retired_before", 32'd1);
        expect_val("st_mem_we_reset", 32'h0);
        expect_val("st_outputs_reset", 32'h0);
        expect_val("st_retired_reset", 32'h0);
        expect_val("st_mem12_unwritten", 32'h0);
        expect_val("st_idle_outputs", 32'h0);
        expect_val("st_restart_mar_we", 32'h1);
        expect_val("st_rerun_retired", 32'd3);
        expect_val("st_rerun_mem12", 32'd9);
        applyStimulus();
        pulse_start();
        cyc = 0;
        while (!mem_we && cyc < 30) begin
            @(negedge clock);
            cyc++;
        end
        observe(mem_we);
        observe(instr_retired);
        reset_n = 1'b0;
        #1;
        observe(mem_we);
        observe(out_vec);
        observe(instr_retired);
        @(negedge clock);
        @(negedge clock);
        observe(mem[12'h012]);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        observe(out_vec);
        pulse_start();
        observe(mar_we);
        wait_halt(60, cyc);
        observe(instr_retired);
        observe(mem[12'h012]);

        checkOutput("sb_drained", exp_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
